// File: rtl/uart_cmd_rx.sv
// uart_cmd_rx: UART receive front end plus line-command parser.
//   Deserialises RX (idle high, LSB first) and assembles lines of the form
//   <letter><hex digits>LF into a command byte and a binary argument, which
//   are presented on a valid/ready handshake.
//   Optional feature macro: UART_CMD_PARITY_EN adds one even-parity bit per frame.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   RX                serial input (double-flopped internally)
//   rx_byte           last good character (unused upper bits 0)
//   rx_byte_valid     1-cycle pulse per good frame
//   cmd_valid/cmd/arg command handshake payload, held until cmd_ready
//   cmd_ready         consumer accepts the command
//   err_frame         pulse: bad stop bit or parity
//   err_syntax        pulse: bad character or too many digits
//   err_overrun       pulse: line completed while cmd_valid was held
//   busy              receiver is mid-frame
module uart_cmd_rx #(
  parameter int unsigned CLK_FREQ  = 50_000_000,
  parameter int unsigned BAUD      = 115200,
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned ARG_W     = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             RX,
  output logic [7:0]       rx_byte,
  output logic             rx_byte_valid,
  output logic             cmd_valid,
  output logic [7:0]       cmd,
  output logic [ARG_W-1:0] arg,
  input  logic             cmd_ready,
  output logic             err_frame,
  output logic             err_syntax,
  output logic             err_overrun,
  output logic             busy
);

  localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int unsigned CNT_W        = $clog2(CLKS_PER_BIT);
  localparam int unsigned BIT_W        = $clog2(DATA_BITS + 1);
  localparam int unsigned MAX_DIGITS   = ARG_W / 4;
  localparam int unsigned DIG_W        = $clog2(MAX_DIGITS + 1);
  localparam logic [7:0]  CH_LF        = 8'h0A;
  localparam logic [7:0]  CH_CR        = 8'h0D;

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} rx_state_t;
  typedef enum logic {P_CMD, P_ARG} p_state_t;

  // ---------------------------------------------------------------- receiver
  logic                 r_rx_meta, r_rx_sync;
  rx_state_t            r_state, w_state_n;
  logic [CNT_W-1:0]     r_cnt, w_cnt_n;
  logic [BIT_W-1:0]     r_bit_idx, w_bit_idx_n;
  logic [DATA_BITS-1:0] r_shift, w_shift_n;
  logic                 r_need_high, w_need_high_n;
  logic                 r_par_err, w_par_err_n;
  logic [7:0]           r_rx_byte, w_rx_byte_n;
  logic                 r_rx_byte_valid, w_rx_byte_valid_n;
  logic                 r_err_frame, w_err_frame_n;
  logic                 r_busy, w_busy_n;
  logic                 w_tick;

  // Two-flop synchroniser; resets to the idle level so reset never looks like a start bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
    end else begin
      r_rx_meta <= RX;
      r_rx_sync <= r_rx_meta;
    end
  end

  // Receiver next-state and registered-output logic.
  always_comb begin
    w_state_n         = r_state;
    w_cnt_n           = r_cnt;
    w_bit_idx_n       = r_bit_idx;
    w_shift_n         = r_shift;
    w_need_high_n     = r_need_high;
    w_par_err_n       = r_par_err;
    w_rx_byte_n       = r_rx_byte;
    w_rx_byte_valid_n = 1'b0;
    w_err_frame_n     = 1'b0;
    w_tick            = (r_cnt == '0);

    if (r_state != S_IDLE && !w_tick) w_cnt_n = r_cnt - CNT_W'(1);

    case (r_state)
      S_IDLE: begin
        // After a framing error the line must return high before re-arming.
        if (r_need_high) begin
          if (r_rx_sync) w_need_high_n = 1'b0;
        end else if (!r_rx_sync) begin
          w_state_n = S_START;
          w_cnt_n   = CNT_W'(CLKS_PER_BIT / 2);
        end
      end
      S_START: begin
        if (w_tick) begin
          if (r_rx_sync) begin
            w_state_n = S_IDLE;
          end else begin
            w_state_n   = S_DATA;
            w_cnt_n     = CNT_W'(CLKS_PER_BIT - 1);
            w_bit_idx_n = '0;
            w_par_err_n = 1'b0;
          end
        end
      end
      S_DATA: begin
        if (w_tick) begin
          w_shift_n = {r_rx_sync, r_shift[DATA_BITS-1:1]};
          w_cnt_n   = CNT_W'(CLKS_PER_BIT - 1);
          if (r_bit_idx == BIT_W'(DATA_BITS - 1)) begin
`ifdef UART_CMD_PARITY_EN
            w_state_n = S_PARITY;
`else
            w_state_n = S_STOP;
`endif
          end else begin
            w_bit_idx_n = r_bit_idx + BIT_W'(1);
          end
        end
      end
`ifdef UART_CMD_PARITY_EN
      S_PARITY: begin
        // Even parity: the parity bit must equal the XOR of the data bits.
        if (w_tick) begin
          w_par_err_n = r_rx_sync ^ (^r_shift);
          w_cnt_n     = CNT_W'(CLKS_PER_BIT - 1);
          w_state_n   = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (w_tick) begin
          w_state_n = S_IDLE;
          if (r_rx_sync && !r_par_err) begin
            w_rx_byte_valid_n = 1'b1;
            w_rx_byte_n       = 8'(r_shift);
          end else begin
            w_err_frame_n = 1'b1;
            w_need_high_n = !r_rx_sync;
          end
        end
      end
      default: w_state_n = S_IDLE;
    endcase

    w_busy_n = (w_state_n != S_IDLE);
  end

  // Receiver state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state         <= S_IDLE;
      r_cnt           <= '0;
      r_bit_idx       <= '0;
      r_shift         <= '0;
      r_need_high     <= 1'b0;
      r_par_err       <= 1'b0;
      r_rx_byte       <= '0;
      r_rx_byte_valid <= 1'b0;
      r_err_frame     <= 1'b0;
      r_busy          <= 1'b0;
    end else begin
      r_state         <= w_state_n;
      r_cnt           <= w_cnt_n;
      r_bit_idx       <= w_bit_idx_n;
      r_shift         <= w_shift_n;
      r_need_high     <= w_need_high_n;
      r_par_err       <= w_par_err_n;
      r_rx_byte       <= w_rx_byte_n;
      r_rx_byte_valid <= w_rx_byte_valid_n;
      r_err_frame     <= w_err_frame_n;
      r_busy          <= w_busy_n;
    end
  end

  // ------------------------------------------------------------------ parser
  p_state_t         r_pstate, w_pstate_n;
  logic [7:0]       r_letter, w_letter_n;
  logic [ARG_W-1:0] r_acc, w_acc_n;
  logic [DIG_W-1:0] r_digits, w_digits_n;
  logic             r_discard, w_discard_n;
  logic             r_cmd_valid, w_cmd_valid_n;
  logic [7:0]       r_cmd, w_cmd_n;
  logic [ARG_W-1:0] r_arg, w_arg_n;
  logic             r_err_syntax, w_err_syntax_n;
  logic             r_err_overrun, w_err_overrun_n;
  logic [4:0]       w_hex;

  // Returns {is_hex, nibble}.
  function automatic logic [4:0] hex_decode(input logic [7:0] c);
    logic [4:0] res;
    res = '0;
    if (c >= 8'h30 && c <= 8'h39)      res = {1'b1, 4'(c - 8'h30)};
    else if (c >= 8'h41 && c <= 8'h46) res = {1'b1, 4'(c - 8'h37)};
    else if (c >= 8'h61 && c <= 8'h66) res = {1'b1, 4'(c - 8'h57)};
    return res;
  endfunction

  // Parser next-state and command-handshake logic.
  always_comb begin
    w_pstate_n      = r_pstate;
    w_letter_n      = r_letter;
    w_acc_n         = r_acc;
    w_digits_n      = r_digits;
    w_discard_n     = r_discard;
    w_cmd_valid_n   = r_cmd_valid;
    w_cmd_n         = r_cmd;
    w_arg_n         = r_arg;
    w_err_syntax_n  = 1'b0;
    w_err_overrun_n = 1'b0;
    w_hex           = hex_decode(r_rx_byte);

    // Handshake is resolved first so a same-cycle LF can reload the slot.
    if (r_cmd_valid && cmd_ready) w_cmd_valid_n = 1'b0;

    if (r_rx_byte_valid) begin
      case (r_pstate)
        P_CMD: begin
          if (r_rx_byte != CH_LF && r_rx_byte != CH_CR) begin
            w_letter_n  = r_rx_byte;
            w_acc_n     = '0;
            w_digits_n  = '0;
            w_discard_n = 1'b0;
            w_pstate_n  = P_ARG;
          end
        end
        P_ARG: begin
          if (r_rx_byte == CH_LF) begin
            w_pstate_n  = P_CMD;
            w_discard_n = 1'b0;
            if (!r_discard) begin
              if (!w_cmd_valid_n) begin
                w_cmd_valid_n = 1'b1;
                w_cmd_n       = r_letter;
                w_arg_n       = r_acc;
              end else begin
                w_err_overrun_n = 1'b1;
              end
            end
          end else if (r_discard || r_rx_byte == CH_CR) begin
            w_discard_n = r_discard;
          end else if (w_hex[4] && r_digits != DIG_W'(MAX_DIGITS)) begin
            w_acc_n    = (r_acc << 4) | ARG_W'(w_hex[3:0]);
            w_digits_n = r_digits + DIG_W'(1);
          end else begin
            w_err_syntax_n = 1'b1;
            w_discard_n    = 1'b1;
          end
        end
        default: w_pstate_n = P_CMD;
      endcase
    end
  end

  // Parser state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pstate      <= P_CMD;
      r_letter      <= '0;
      r_acc         <= '0;
      r_digits      <= '0;
      r_discard     <= 1'b0;
      r_cmd_valid   <= 1'b0;
      r_cmd         <= '0;
      r_arg         <= '0;
      r_err_syntax  <= 1'b0;
      r_err_overrun <= 1'b0;
    end else begin
      r_pstate      <= w_pstate_n;
      r_letter      <= w_letter_n;
      r_acc         <= w_acc_n;
      r_digits      <= w_digits_n;
      r_discard     <= w_discard_n;
      r_cmd_valid   <= w_cmd_valid_n;
      r_cmd         <= w_cmd_n;
      r_arg         <= w_arg_n;
      r_err_syntax  <= w_err_syntax_n;
      r_err_overrun <= w_err_overrun_n;
    end
  end

  assign rx_byte       = r_rx_byte;
  assign rx_byte_valid = r_rx_byte_valid;
  assign cmd_valid     = r_cmd_valid;
  assign cmd           = r_cmd;
  assign arg           = r_arg;
  assign err_frame     = r_err_frame;
  assign err_syntax    = r_err_syntax;
  assign err_overrun   = r_err_overrun;
  assign busy          = r_busy;

endmodule

// File: doc/uart_cmd_rx.md
# uart_cmd_rx

Parametrised UART receive front end plus line-command parser for the bitcoin-miner controllers. It replaces the fixed-rate receiver that currently sits in front of `sha2_controller`. Serial `RX` is deserialised, and lines of the form `<letter><hex digits>LF` are assembled into a command byte and a binary argument. Each completed command is presented on a valid/ready handshake, and framing, syntax and overrun faults are flagged as one-cycle pulses.

## Interface
Parameters:
- `CLK_FREQ`, 50_000_000: clock frequency in Hz.
- `BAUD`, 115200: line rate. `CLKS_PER_BIT = CLK_FREQ/BAUD` (integer division, must be ≥ 4).
- `DATA_BITS`, 8: data bits per frame, 5..8, LSB first. Upper unused bits of `rx_byte` are 0.
- `ARG_W`, 32: argument width, a multiple of 4. Maximum hex digits = `ARG_W/4`.

Ports:
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `RX`  in  1  serial line, idle high. Double-flopped internally before use.
- `rx_byte`  out  8  last received character.
- `rx_byte_valid`  out  1  one-cycle pulse per good frame.
- `cmd_valid`  out  1  command available.
- `cmd`  out  8  command letter.
- `arg`  out  `ARG_W`  parsed argument.
- `cmd_ready`  in  1  consumer accepts the command.
- `err_frame`  out  1  pulse: bad stop bit (or parity, see Configuration).
- `err_syntax`  out  1  pulse: bad character or too many digits.
- `err_overrun`  out  1  pulse: a line completed while `cmd_valid` was held.
- `busy`  out  1  high while the receiver is mid-frame.

## Operation
Receiver FSM: IDLE → START → DATA → [PARITY] → STOP → IDLE.
- IDLE: wait for the synchronised `RX`=0. Load the bit counter with `CLKS_PER_BIT/2`.
- START: at the half-bit point, re-sample. If `RX`=1 it was a glitch: return to IDLE with no error. If `RX`=0, proceed to DATA.
- DATA: sample every `CLKS_PER_BIT` cycles, shifting in LSB first, for `DATA_BITS` bits.
- STOP: sample once.
  - 1 → `rx_byte_valid` pulse and byte handed to the parser.
  - 0 → `err_frame` pulse and the byte is discarded. The parser is not touched. The FSM then waits in IDLE for `RX`=1 before arming again.

Parser FSM: P_CMD, P_ARG.
- P_CMD:
  - LF (0x0A) or CR (0x0D) is ignored.
  - Any other byte is latched as the pending letter, the accumulator is cleared, and the FSM moves to P_ARG.
- P_ARG:
  - Hex digit (0-9, A-F, a-f): `acc <= {acc[ARG_W-5:0], nibble}`, digit count +1.
  - CR is ignored.
  - LF completes the line. Zero digits is legal and gives arg = 0.
    - If `cmd_valid`=0: load `cmd` and `arg`, set `cmd_valid`.
    - If `cmd_valid`=1: drop the line and pulse `err_overrun`.
    - In both cases return to P_CMD.
  - Any other byte, or a digit beyond `ARG_W/4`: pulse `err_syntax` and discard the line. The FSM then ignores bytes until LF, then returns to P_CMD. The discard flag clears on LF.
- `cmd_valid` stays high, with `cmd` and `arg` stable, until a cycle where `cmd_valid && cmd_ready`; it clears on the next edge.
- `cmd_ready` with no `cmd_valid` has no effect.

## Timing
- Reset values: all outputs 0, including `rx_byte`, `cmd`, `arg`, every pulse, and `busy`. Both FSMs are in IDLE / P_CMD with counters and accumulator cleared.
- Reset mid-frame aborts the frame silently. No error pulses during or immediately after reset.
- `rx_byte_valid` fires 1 cycle after the stop-bit sample point, i.e. ≈(`DATA_BITS`+1.5)·`CLKS_PER_BIT`+3 cycles after the start edge (2 synchroniser cycles included).
- `cmd_valid` rises 1 cycle after the `rx_byte_valid` of the terminating LF.
- The acceptance edge and a simultaneous LF completion in the same cycle: the handshake is processed first, so the new command loads and `cmd_valid` stays high. No overrun is reported.
- Error pulses are exactly 1 cycle wide and mutually exclusive per byte.
- `busy` is high from START entry until return to IDLE.

## Configuration
- `UART_CMD_PARITY_EN`:
  - Defined: one even-parity bit follows the data bits. The PARITY state samples it.
  - Mismatch: the byte is discarded and `err_frame` pulses after the stop bit, even if the stop bit is good.
  - Undefined: no PARITY state and the frame is `DATA_BITS`+2 bits long.

## Test plan
- 50 MHz, 115200 baud, send "L1123" + LF with `cmd_ready`=1 → one `cmd_valid` cycle with `cmd`=8'h4C, `arg`=32'h00001123. Five chars then LF give six `rx_byte_valid` pulses.
- Send "Sdeadbeef" + CR + LF, `cmd_ready`=0 for 1000 cycles, then 1 → `cmd`=8'h53 and `arg`=32'hDEADBEEF held stable until the accept edge. `cmd_valid` drops 1 cycle after `cmd_ready`.
- `ARG_W`=16, send "L12345" + LF → `err_syntax` on the '5', no `cmd_valid`. Then send "L7" + LF → `arg`=16'h0007.
- Send "L1G" + LF → `err_syntax` on 'G', no command. Send a frame with stop bit forced 0 → `err_frame`, no `rx_byte_valid`, and parser state unchanged.
- Two lines "A1" + LF, "B2" + LF with `cmd_ready`=0 → first held (`cmd`=8'h41, `arg`=1) and `err_overrun` on the second LF. Also a 0.3-bit low glitch on `RX` → no pulse of any kind.
- Assert `rst_n`=0 mid-DATA of "L" → all outputs 0. After release, send "P" + LF → `cmd`=8'h50, `arg`=0. With `UART_CMD_PARITY_EN` defined, a wrong parity bit → `err_frame` only.
